// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency, word-addressed data-memory responder for the
// pipeline's memory stage. A load/store request accepted in IDLE is serviced
// after WAIT_CYCLES extra wait cycles. stallM is held high from acceptance
// until the access edge, and the result is presented in a one-cycle DONE state.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits (array depth 2**ADDR_WIDTH x 32 bits)
//   WAIT_CYCLES - extra array wait cycles, 0..15
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   memreadM   in   load request
//   memwriteM  in   store request (wins over memreadM when both are high)
//   aluoutM    in   byte address; word index is aluoutM[ADDR_WIDTH+1:2]
//   writedataM in   store data
//   byteenM    in   store lane enables (only when DMEM_BYTEMASK_EN is defined)
//   readdataM  out  registered load data, held until the next load completes
//   stallM     out  pipeline freeze request
//
// Build option: define DMEM_BYTEMASK_EN to add byteenM and per-lane stores;
// without it every store writes the full word.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
`ifdef DMEM_BYTEMASK_EN
  input  logic [3:0]  byteenM,
`endif
  output logic [31:0] readdataM,
  output logic        stallM
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    req;

  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_W-1:0]       data_p0;
  logic                    is_wr_p0;
  logic [3:0]              lanes_p0;
  logic [3:0]              lanes_in;

  logic [DATA_W-1:0]       mem [DEPTH];

  // Byte-offset and high address bits are dropped: accesses are word
  // aligned and wrap modulo the array depth.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{aluoutM[31:ADDR_WIDTH+2], aluoutM[1:0]};

  assign req = memreadM | memwriteM;

`ifdef DMEM_BYTEMASK_EN
  assign lanes_in = byteenM;
`else
  assign lanes_in = 4'hF;
`endif

  // Freeze starts in the same cycle the request appears in IDLE so the M
  // stage holds its request; DONE releases the pipeline.
  always_comb begin
    stallM = 1'b0;
    if (!reset) begin
      stallM = (state == WAIT) || ((state == IDLE) && req);
    end
  end

  // Control FSM: acceptance, wait countdown, access, single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      readdataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            if (!is_wr_p0) readdataM <= mem[addr_p0];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: request capture. Only the captured copy drives the access, so
  // input changes while waiting are ignored.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      addr_p0  <= aluoutM[ADDR_WIDTH+1:2];
      data_p0  <= writedataM;
      is_wr_p0 <= memwriteM;
      lanes_p0 <= lanes_in;
    end
  end

  // Array write on the access edge; reset suppresses it, discarding an
  // in-flight store.
  always_ff @(posedge clk) begin
    if (!reset && (state == WAIT) && (cnt == 4'd0) && is_wr_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_p0[i]) mem[addr_p0][8*i +: 8] <= data_p0[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder at the far end of the pipeline's memory-stage interface. It accepts load/store requests from the M stage, models a fixed-latency word-addressed RAM, and returns load data on `readdataM`. While an access is in flight it raises `stallM`, which the hazard logic uses to freeze F/D/E/M and bubble W.

## Interface
- `ADDR_WIDTH`, default 6: word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 2: extra array-access wait cycles; legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `memreadM`  in  1  load request from the M stage.
- `memwriteM`  in  1  store request from the M stage.
- `aluoutM`  in  32  byte address; word index is `aluoutM[ADDR_WIDTH+1:2]`.
- `writedataM`  in  32  store data.
- `byteenM`  in  4  store lane enables, bit i selects bits 8i+7:8i. Present only with `DMEM_BYTEMASK_EN`.
- `readdataM`  out  32  registered load data.
- `stallM`  out  1  pipeline freeze request.

## Operation
- States: IDLE, WAIT, DONE. Reset: state IDLE, `readdataM`=0, `stallM`=0, counter 0. Array contents are not reset.
- Request: `memreadM | memwriteM`. If both are high, the access is a write; `readdataM` is unchanged.
- IDLE with request:
  - `stallM`=1 combinationally.
  - Capture address, data, type and lanes.
  - Load counter with WAIT_CYCLES.
  - Go to WAIT.
- IDLE without request: `stallM`=0; stay in IDLE.
- WAIT:
  - `stallM`=1.
  - If counter≠0, decrement the counter.
  - If counter=0, perform the access on this edge and go to DONE. A write updates the array. A read loads `readdataM` from the array.
- DONE: `stallM`=0, so the pipeline advances at the end of this cycle. Next state is IDLE unconditionally; the same request is never re-accepted.
- Address arithmetic:
  - Bits [1:0] are ignored; accesses are word-aligned.
  - Bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the array depth.
- `readdataM` holds its value until the next read completes. Writes never change it.
- Captured request fields are used for the access, not the live inputs. Input changes during WAIT have no effect.
- Reset in any state:
  - Next state is IDLE.
  - An in-flight write is discarded; the array is untouched.
  - `readdataM`=0.
  - `stallM` is forced to 0 during the reset cycle.

## Timing
- Request seen in cycle T (IDLE). `stallM` is high in cycles T..T+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles. The access happens at the end of T+WAIT_CYCLES+1.
- DONE is cycle T+WAIT_CYCLES+2. `stallM` is 0 and `readdataM` is valid in that cycle.
- Back-to-back requests: a new request present in the cycle after DONE is accepted immediately. Minimum initiation interval is WAIT_CYCLES+3 cycles.
- No combinational path from `aluoutM`/`writedataM` to outputs. `stallM` depends combinationally only on state, `reset`, `memreadM` and `memwriteM`.

## Configuration
- `DMEM_BYTEMASK_EN` defined:
  - `byteenM` port exists; a store writes only the enabled lanes.
  - `byteenM`=4'b0000 makes the write a no-op but still runs the full handshake and stall.
- Undefined: no `byteenM` port; every store writes all 32 bits.

## Test plan
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x40, then load 0x40 → `stallM` high exactly 4 cycles per access; `readdataM`=0xDEADBEEF in the load's DONE cycle.
- Store to 0x40 immediately followed (cycle after DONE) by a load of 0x40 → load accepted with no idle gap; returns the stored value; each request serviced exactly once.
- WAIT_CYCLES=0 build: load request → `stallM` high exactly 2 cycles; data valid in the 3rd cycle.
- Array holds 0x11111111 at 0x08; start a store of 0x22222222 and assert `reset` in the second WAIT cycle → `stallM`=0 and `readdataM`=0 after reset; a later load of 0x08 returns 0x11111111.
- ADDR_WIDTH=6: store 0xCAFEF00D to 0x100, then load 0x000 and 0x003 → both return 0xCAFEF00D.
- `DMEM_BYTEMASK_EN`: word 0x11223344, store 0xAABBCCDD with `byteenM`=4'b0101 → load returns 0x11BB33DD. Simultaneous `memreadM`/`memwriteM` → treated as a write; `readdataM` unchanged.
